control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL take parameters: BITS, default 32, datapath/IR width; REGISTERS, default 16, GPR count.
REQ-002 SHALL have port Clock, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-004 SHALL have port Run, input, 1, leaves IDLE/HALT and starts fetch.
REQ-005 SHALL have port Stop, input, 1, requests halt at the next instruction boundary.
REQ-006 SHALL have port MemReady, input, 1, memory read data valid on Mdatain.
REQ-007 SHALL have port IRVal, input, BITS, datapath IR contents; fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
REQ-008 SHALL have ports PCout, MDRout, Zlowout, Zhighout, HIout, LOout, output, 1 each, bus drivers.
REQ-009 SHALL have ports PCin, IRin, RYin, RZin, MARin, MDRin, HIin, LOin, Read, IncPC, output, 1 each, load/memory strobes.
REQ-010 SHALL have ports ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, output, 1 each, ALU op selects.
REQ-011 SHALL have ports GPRin, GPRout, output, REGISTERS each, one-hot register select.
REQ-012 SHALL have ports Halted (1, in HALT) and Illegal (1, one-cycle pulse), outputs.

Function
REQ-013 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT in one registered state variable; all outputs SHALL be Moore-decoded from state plus IRVal.
REQ-014 IDLE: all outputs 0; Run=1 -> T0.
REQ-015 T0: PCout, MARin, IncPC, RZin = 1; -> T1.
REQ-016 T1: Zlowout, PCin, Read, MDRin = 1; SHALL hold in T1 while MemReady=0; -> T2 on MemReady=1.
REQ-017 T2: MDRout, IRin = 1; -> T3.
REQ-018 Opcodes: 00011 ADD, 00100 SUB, 00101 SHR, 00110 SHL, 00111 ROR, 01000 ROL, 01001 AND, 01010 OR, 01111 MUL, 10000 DIV, 10001 NEGATE, 10010 NOT, 11011 HALT; every other value illegal.
REQ-019 Binary ops (ADD..OR): T3 GPRout[rb], RYin; T4 GPRout[rc], op strobe, RZin; T5 Zlowout, GPRin[ra]; then boundary.
REQ-020 MUL/DIV: T3, T4 as REQ-019; T5 Zlowout, LOin; T6 Zhighout, HIin; then boundary.
REQ-021 NEGATE/NOT: T3 GPRout[rb], op strobe, RZin; T4 Zlowout, GPRin[ra]; then boundary.
REQ-022 HALT opcode: T3 -> HALT, no strobes.
REQ-023 Illegal opcode: Illegal=1 during T3, no other strobes, then boundary.
REQ-024 Boundary: -> HALT if Stop was sampled 1 during any state of the current instruction (sticky flag, cleared on entering HALT), else -> T0.
REQ-025 HALT: Halted=1, all other outputs 0; Run=1 -> T0; Run and Stop both 1 in HALT -> T0 with the Stop flag set (exactly one instruction executes).
REQ-026 At most one ALU op strobe and at most one bus driver SHALL be 1 in any cycle; GPRin/GPRout SHALL be all-zero or one-hot.
REQ-027 Register index decoding SHALL use ra/rb/rc modulo REGISTERS.

Reset
REQ-028 reset=0 at a rising edge SHALL force IDLE, clear the Stop flag, and drive every output 0 in the following cycle, including mid-instruction and mid-T1 wait.
REQ-029 reset SHALL take priority over Run, Stop and MemReady.

Structure
REQ-030 State encoding, opcode constants and IR field bit positions SHALL live in a shared package, cpu_defs.
REQ-031 The opcode-to-control decode SHALL be a combinational sub-module, instr_decoder; the FSM stays in control_unit.

Verification
REQ-032 Reset, Run=1, MemReady=1, IRVal=32'h4A920000 -> T0..T5 in 6 cycles; T3 GPRout=0x0004, RYin; T4 GPRout=0x0010, AND, RZin; T5 GPRin=0x0020, Zlowout.
REQ-033 IRVal=32'h78000000 (MUL R0,R0,R0) -> T5 LOin+Zlowout, T6 HIin+Zhighout, then T0.
REQ-034 MemReady held 0 for 3 cycles in T1 -> T1 held 4 cycles with Read=1, no IRin until MemReady=1.
REQ-035 Stop pulsed in T4 of ADD -> T5 completes, then HALT with Halted=1; Run=1 -> T0.
REQ-036 IRVal opcode 11111 -> Illegal=1 for one cycle in T3, zero GPR strobes, next state T0.
REQ-037 reset=0 during T4 -> next cycle IDLE, all outputs 0, GPRout=0x0000.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// instruction field positions, opcode values and the control-word layout.
package cpu_defs;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [4:0] OPC_ADD    = 5'b00011;
    localparam logic [4:0] OPC_SUB    = 5'b00100;
    localparam logic [4:0] OPC_SHR    = 5'b00101;
    localparam logic [4:0] OPC_SHL    = 5'b00110;
    localparam logic [4:0] OPC_ROR    = 5'b00111;
    localparam logic [4:0] OPC_ROL    = 5'b01000;
    localparam logic [4:0] OPC_AND    = 5'b01001;
    localparam logic [4:0] OPC_OR     = 5'b01010;
    localparam logic [4:0] OPC_MUL    = 5'b01111;
    localparam logic [4:0] OPC_DIV    = 5'b10000;
    localparam logic [4:0] OPC_NEGATE = 5'b10001;
    localparam logic [4:0] OPC_NOT    = 5'b10010;
    localparam logic [4:0] OPC_HALT   = 5'b11011;

    // Execution shape of an instruction; decides how many T-states it uses.
    typedef enum logic [2:0] {
        CLS_BINARY,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic op_add, op_sub, op_mul, op_div, op_shr, op_shl;
        logic op_ror, op_rol, op_and, op_or, op_negate, op_not;
    } alu_sel_t;

    typedef struct packed {
        logic     pc_out, mdr_out, zlow_out, zhigh_out, hi_out, lo_out;
        logic     pc_in, ir_in, ry_in, rz_in, mar_in, mdr_in, hi_in, lo_in;
        logic     read, inc_pc;
        alu_sel_t alu;
        logic     halted, illegal;
    } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Handshake and strobe bundle between the control unit (master) and the datapath (slave).
// Run/Stop/MemReady are level inputs sampled at every rising edge; all strobes are level outputs.
interface control_unit_if #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
);
    logic                 Run, Stop, MemReady;
    logic [BITS-1:0]      IRVal;
    logic                 PCout, MDRout, Zlowout, Zhighout, HIout, LOout;
    logic                 PCin, IRin, RYin, RZin, MARin, MDRin, HIin, LOin, Read, IncPC;
    logic                 ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;
    logic [REGISTERS-1:0] GPRin, GPRout;
    logic                 Halted, Illegal;

    modport master (
        input  Run, Stop, MemReady, IRVal,
        output PCout, MDRout, Zlowout, Zhighout, HIout, LOout,
        output PCin, IRin, RYin, RZin, MARin, MDRin, HIin, LOin, Read, IncPC,
        output ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
        output GPRin, GPRout, Halted, Illegal
    );

    modport slave (
        output Run, Stop, MemReady, IRVal,
        input  PCout, MDRout, Zlowout, Zhighout, HIout, LOout,
        input  PCin, IRin, RYin, RZin, MARin, MDRin, HIin, LOin, Read, IncPC,
        input  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
        input  GPRin, GPRout, Halted, Illegal
    );
endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of (state, IR) into the control word and one-hot register selects.
module instr_decoder import cpu_defs::*; #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  state_t               state_i,
    input  logic [BITS-1:0]      ir_i,
    output ctrl_t                ctrl_o,
    output logic [REGISTERS-1:0] gpr_in_o,
    output logic [REGISTERS-1:0] gpr_out_o,
    output op_class_t            op_class_o
);
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    alu_sel_t   alu;
    op_class_t  op_class;
    logic       unused_ir;

    assign opcode     = ir_i[OP_MSB:OP_LSB];
    assign ra         = ir_i[RA_MSB:RA_LSB];
    assign rb         = ir_i[RB_MSB:RB_LSB];
    assign rc         = ir_i[RC_MSB:RC_LSB];
    assign unused_ir  = ^ir_i;
    assign op_class_o = op_class;

    // Register fields wrap modulo the register count.
    function automatic logic [REGISTERS-1:0] reg_sel(input logic [3:0] idx);
        return REGISTERS'(1) << (32'(idx) % REGISTERS);
    endfunction

    always_comb begin
        op_class = CLS_ILLEGAL;
        alu      = '0;
        case (opcode)
            OPC_ADD:    begin op_class = CLS_BINARY; alu.op_add    = 1'b1; end
            OPC_SUB:    begin op_class = CLS_BINARY; alu.op_sub    = 1'b1; end
            OPC_SHR:    begin op_class = CLS_BINARY; alu.op_shr    = 1'b1; end
            OPC_SHL:    begin op_class = CLS_BINARY; alu.op_shl    = 1'b1; end
            OPC_ROR:    begin op_class = CLS_BINARY; alu.op_ror    = 1'b1; end
            OPC_ROL:    begin op_class = CLS_BINARY; alu.op_rol    = 1'b1; end
            OPC_AND:    begin op_class = CLS_BINARY; alu.op_and    = 1'b1; end
            OPC_OR:     begin op_class = CLS_BINARY; alu.op_or     = 1'b1; end
            OPC_MUL:    begin op_class = CLS_MULDIV; alu.op_mul    = 1'b1; end
            OPC_DIV:    begin op_class = CLS_MULDIV; alu.op_div    = 1'b1; end
            OPC_NEGATE: begin op_class = CLS_UNARY;  alu.op_negate = 1'b1; end
            OPC_NOT:    begin op_class = CLS_UNARY;  alu.op_not    = 1'b1; end
            OPC_HALT:   op_class = CLS_HALT;
            default:    op_class = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        ctrl_o    = '0;
        gpr_in_o  = '0;
        gpr_out_o = '0;
        case (state_i)
            S_T0: begin
                ctrl_o.pc_out = 1'b1; ctrl_o.mar_in = 1'b1;
                ctrl_o.inc_pc = 1'b1; ctrl_o.rz_in  = 1'b1;
            end
            S_T1: begin
                ctrl_o.zlow_out = 1'b1; ctrl_o.pc_in  = 1'b1;
                ctrl_o.read     = 1'b1; ctrl_o.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl_o.mdr_out = 1'b1; ctrl_o.ir_in = 1'b1;
            end
            S_T3: case (op_class)
                CLS_BINARY, CLS_MULDIV: begin
                    gpr_out_o = reg_sel(rb); ctrl_o.ry_in = 1'b1;
                end
                CLS_UNARY: begin
                    gpr_out_o = reg_sel(rb); ctrl_o.alu = alu; ctrl_o.rz_in = 1'b1;
                end
                CLS_ILLEGAL: ctrl_o.illegal = 1'b1;
                default: ;
            endcase
            S_T4: case (op_class)
                CLS_BINARY, CLS_MULDIV: begin
                    gpr_out_o = reg_sel(rc); ctrl_o.alu = alu; ctrl_o.rz_in = 1'b1;
                end
                CLS_UNARY: begin
                    ctrl_o.zlow_out = 1'b1; gpr_in_o = reg_sel(ra);
                end
                default: ;
            endcase
            S_T5: case (op_class)
                CLS_BINARY: begin ctrl_o.zlow_out = 1'b1; gpr_in_o = reg_sel(ra); end
                CLS_MULDIV: begin ctrl_o.zlow_out = 1'b1; ctrl_o.lo_in = 1'b1; end
                default: ;
            endcase
            S_T6: if (op_class == CLS_MULDIV) begin
                ctrl_o.zhigh_out = 1'b1; ctrl_o.hi_in = 1'b1;
            end
            S_HALT: ctrl_o.halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM: fetch (T0-T2), execute (T3-T6), sticky Stop-to-HALT at instruction boundaries.
module control_unit import cpu_defs::*; #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  logic               Clock,
    input  logic               reset,
    control_unit_if.master     bus,
    output state_t             state_o
);
    state_t               state_q;
    logic                 stop_q;
    logic                 stop_seen;
    ctrl_t                ctrl;
    op_class_t            op_class;
    logic [REGISTERS-1:0] gpr_in, gpr_out;

    instr_decoder #(.BITS(BITS), .REGISTERS(REGISTERS)) u_dec (
        .state_i    (state_q),
        .ir_i       (bus.IRVal),
        .ctrl_o     (ctrl),
        .gpr_in_o   (gpr_in),
        .gpr_out_o  (gpr_out),
        .op_class_o (op_class)
    );

    // Stop asserted in the current cycle counts as seen for this instruction.
    assign stop_seen = stop_q | bus.Stop;

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            stop_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.Run) state_q <= S_T0;
                S_HALT: if (bus.Run) begin
                    state_q <= S_T0;
                    stop_q  <= bus.Stop;
                end
                S_T0: begin state_q <= S_T1; stop_q <= stop_seen; end
                S_T1: begin
                    stop_q <= stop_seen;
                    if (bus.MemReady) state_q <= S_T2;
                end
                S_T2: begin state_q <= S_T3; stop_q <= stop_seen; end
                S_T3: case (op_class)
                    CLS_HALT: begin state_q <= S_HALT; stop_q <= 1'b0; end
                    CLS_ILLEGAL: begin
                        state_q <= stop_seen ? S_HALT : S_T0;
                        stop_q  <= 1'b0;
                    end
                    default: begin state_q <= S_T4; stop_q <= stop_seen; end
                endcase
                S_T4: if (op_class == CLS_UNARY) begin
                    state_q <= stop_seen ? S_HALT : S_T0;
                    stop_q  <= 1'b0;
                end else begin
                    state_q <= S_T5;
                    stop_q  <= stop_seen;
                end
                S_T5: if (op_class == CLS_MULDIV) begin
                    state_q <= S_T6;
                    stop_q  <= stop_seen;
                end else begin
                    state_q <= stop_seen ? S_HALT : S_T0;
                    stop_q  <= 1'b0;
                end
                S_T6: begin
                    state_q <= stop_seen ? S_HALT : S_T0;
                    stop_q  <= 1'b0;
                end
                default: begin state_q <= S_IDLE; stop_q <= 1'b0; end
            endcase
        end
    end

    assign state_o      = state_q;
    assign bus.PCout    = ctrl.pc_out;
    assign bus.MDRout   = ctrl.mdr_out;
    assign bus.Zlowout  = ctrl.zlow_out;
    assign bus.Zhighout = ctrl.zhigh_out;
    assign bus.HIout    = ctrl.hi_out;
    assign bus.LOout    = ctrl.lo_out;
    assign bus.PCin     = ctrl.pc_in;
    assign bus.IRin     = ctrl.ir_in;
    assign bus.RYin     = ctrl.ry_in;
    assign bus.RZin     = ctrl.rz_in;
    assign bus.MARin    = ctrl.mar_in;
    assign bus.MDRin    = ctrl.mdr_in;
    assign bus.HIin     = ctrl.hi_in;
    assign bus.LOin     = ctrl.lo_in;
    assign bus.Read     = ctrl.read;
    assign bus.IncPC    = ctrl.inc_pc;
    assign bus.ADD      = ctrl.alu.op_add;
    assign bus.SUB      = ctrl.alu.op_sub;
    assign bus.MUL      = ctrl.alu.op_mul;
    assign bus.DIV      = ctrl.alu.op_div;
    assign bus.SHR      = ctrl.alu.op_shr;
    assign bus.SHL      = ctrl.alu.op_shl;
    assign bus.ROR      = ctrl.alu.op_ror;
    assign bus.ROL      = ctrl.alu.op_rol;
    assign bus.AND      = ctrl.alu.op_and;
    assign bus.OR       = ctrl.alu.op_or;
    assign bus.NEGATE   = ctrl.alu.op_negate;
    assign bus.NOT      = ctrl.alu.op_not;
    assign bus.GPRin    = gpr_in;
    assign bus.GPRout   = gpr_out;
    assign bus.Halted   = ctrl.halted;
    assign bus.Illegal  = ctrl.illegal;
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios then random instruction streams, each cycle's outputs
// compared against a per-instruction list of expected control words built from the opcode rules.
module tb_control_unit;
    import cpu_defs::*;

    logic   Clock, reset;
    state_t dbg_state_unused;

    control_unit_if #(.BITS(32), .REGISTERS(16)) bus ();

    control_unit #(.BITS(32), .REGISTERS(16)) dut (
        .Clock   (Clock),
        .reset   (reset),
        .bus     (bus),
        .state_o (dbg_state_unused)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Observed word: [15:0] GPRout, [31:16] GPRin, [47:32] bus/load strobes, [59:48] ALU ops, 60 Halted, 61 Illegal.
    localparam logic [63:0] M_PCOUT  = 64'h1 << 32;
    localparam logic [63:0] M_MDROUT = 64'h1 << 33;
    localparam logic [63:0] M_ZLOW   = 64'h1 << 34;
    localparam logic [63:0] M_ZHIGH  = 64'h1 << 35;
    localparam logic [63:0] M_PCIN   = 64'h1 << 38;
    localparam logic [63:0] M_IRIN   = 64'h1 << 39;
    localparam logic [63:0] M_RYIN   = 64'h1 << 40;
    localparam logic [63:0] M_RZIN   = 64'h1 << 41;
    localparam logic [63:0] M_MARIN  = 64'h1 << 42;
    localparam logic [63:0] M_MDRIN  = 64'h1 << 43;
    localparam logic [63:0] M_HIIN   = 64'h1 << 44;
    localparam logic [63:0] M_LOIN   = 64'h1 << 45;
    localparam logic [63:0] M_READ   = 64'h1 << 46;
    localparam logic [63:0] M_INCPC  = 64'h1 << 47;
    localparam logic [63:0] M_HALTED = 64'h1 << 60;
    localparam logic [63:0] M_ILL    = 64'h1 << 61;
    localparam logic [63:0] W_T0     = M_PCOUT | M_MARIN | M_INCPC | M_RZIN;
    localparam logic [63:0] W_T1     = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
    localparam logic [63:0] W_T2     = M_MDROUT | M_IRIN;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] obs;
    logic [63:0] exp_q[$];
    logic [4:0]  legal_ops[13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                   5'd15, 5'd16, 5'd17, 5'd18, 5'd27};

    assign obs = {2'b00, bus.Illegal, bus.Halted,
                  bus.NOT, bus.NEGATE, bus.OR, bus.AND, bus.ROL, bus.ROR,
                  bus.SHL, bus.SHR, bus.DIV, bus.MUL, bus.SUB, bus.ADD,
                  bus.IncPC, bus.Read, bus.LOin, bus.HIin, bus.MDRin, bus.MARin,
                  bus.RZin, bus.RYin, bus.IRin, bus.PCin, bus.LOout, bus.HIout,
                  bus.Zhighout, bus.Zlowout, bus.MDRout, bus.PCout,
                  bus.GPRin, bus.GPRout};

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input logic [63:0] expv, input string tag);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // kind: 0 binary, 1 mul/div, 2 unary, 3 halt, 4 illegal; ab = observed-word bit of the ALU op.
    function automatic void op_info(input logic [4:0] op, output int kind, output int ab);
        kind = 0;
        ab   = -1;
        case (op)
            5'd3:  ab = 48;
            5'd4:  ab = 49;
            5'd5:  ab = 52;
            5'd6:  ab = 53;
            5'd7:  ab = 54;
            5'd8:  ab = 55;
            5'd9:  ab = 56;
            5'd10: ab = 57;
            5'd15: begin kind = 1; ab = 50; end
            5'd16: begin kind = 1; ab = 51; end
            5'd17: begin kind = 2; ab = 58; end
            5'd18: begin kind = 2; ab = 59; end
            5'd27: kind = 3;
            default: kind = 4;
        endcase
    endfunction

    function automatic logic [63:0] gout(input logic [3:0] r);
        return 64'h1 << r;
    endfunction

    function automatic logic [63:0] gin(input logic [3:0] r);
        return 64'h1 << (16 + int'(r));
    endfunction

    task automatic plan(input logic [31:0] ir, input int waits, output bit to_halt);
        int          kind, ab;
        logic [63:0] alu_m;
        logic [3:0]  ra, rb, rc;
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        op_info(ir[31:27], kind, ab);
        alu_m   = (ab >= 0) ? (64'h1 << ab) : 64'h0;
        to_halt = (kind == 3);
        exp_q.delete();
        exp_q.push_back(W_T0);
        repeat (waits + 1) exp_q.push_back(W_T1);
        exp_q.push_back(W_T2);
        case (kind)
            0: begin
                exp_q.push_back(gout(rb) | M_RYIN);
                exp_q.push_back(gout(rc) | alu_m | M_RZIN);
                exp_q.push_back(M_ZLOW | gin(ra));
            end
            1: begin
                exp_q.push_back(gout(rb) | M_RYIN);
                exp_q.push_back(gout(rc) | alu_m | M_RZIN);
                exp_q.push_back(M_ZLOW | M_LOIN);
                exp_q.push_back(M_ZHIGH | M_HIIN);
            end
            2: begin
                exp_q.push_back(gout(rb) | alu_m | M_RZIN);
                exp_q.push_back(M_ZLOW | gin(ra));
            end
            3: exp_q.push_back(64'h0);
            default: exp_q.push_back(M_ILL);
        endcase
    endtask

    // Runs one instruction starting in T0. ret: 0 -> next is T0, 1 -> HALT, 2 -> reset to IDLE.
    task automatic exec(input logic [31:0] ir, input int waits, input bit stop_pre,
                        input int stop_at, input int rst_at, input string tag, output int ret);
        bit          to_halt, stopped;
        int          n;
        logic [63:0] e;
        plan(ir, waits, to_halt);
        bus.IRVal = ir;
        bus.Run   = 1'b0;
        stopped   = stop_pre;
        n         = exp_q.size();
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            check(e, tag);
            if (k == rst_at) begin
                reset = 1'b0;
                bus.Run = 1'b1; bus.Stop = 1'b1; bus.MemReady = 1'b1;
                tick();
                check(64'h0, {tag, "_rst"});
                reset = 1'b1;
                bus.Run = 1'b0; bus.Stop = 1'b0;
                ret = 2;
                return;
            end
            bus.MemReady = (k >= 1 && k <= waits) ? 1'b0 : 1'b1;
            bus.Stop     = (k == stop_at);
            if (k == stop_at) stopped = 1'b1;
            tick();
        end
        bus.Stop = 1'b0;
        ret = (to_halt || stopped) ? 1 : 0;
    endtask

    // Brings the unit from wherever exec left it back into T0.
    task automatic follow(input int ret, input bit next_stop, output bit stop_pre);
        stop_pre = 1'b0;
        if (ret == 1) begin
            check(M_HALTED, "halted");
            repeat ($urandom_range(0, 2)) begin
                tick();
                check(M_HALTED, "halt_hold");
            end
            bus.Run  = 1'b1;
            bus.Stop = next_stop;
            tick();
            bus.Run  = 1'b0;
            bus.Stop = 1'b0;
            stop_pre = next_stop;
        end else if (ret == 2) begin
            tick();
            check(64'h0, "idle_hold");
            bus.Run = 1'b1;
            tick();
            bus.Run = 1'b0;
        end
    endtask

    initial begin
        int          ret;
        bit          sp;
        logic [4:0]  op;
        logic [31:0] ir;
        reset        = 1'b0;
        bus.Run      = 1'b0;
        bus.Stop     = 1'b0;
        bus.MemReady = 1'b0;
        bus.IRVal    = '0;
        tick();
        tick();
        check(64'h0, "reset_idle");
        reset = 1'b1;
        tick();
        check(64'h0, "idle_no_run");
        bus.Run = 1'b1;
        tick();
        bus.Run = 1'b0;

        exec(32'h4A920000, 0, 1'b0, -1, -1, "and_r5_r2_r4", ret);
        exec(32'h78000000, 0, 1'b0, -1, -1, "mul_r0", ret);
        exec(32'h19890000, 3, 1'b0, -1, -1, "add_memwait", ret);
        exec(32'h19890000, 0, 1'b0, 4, -1, "add_stop_t4", ret);
        follow(ret, 1'b0, sp);
        exec(32'hF8000000, 0, sp, -1, -1, "illegal_11111", ret);
        exec(32'h8BE00000, 1, 1'b0, -1, -1, "negate", ret);
        exec(32'hD8000000, 0, 1'b0, -1, -1, "halt_op", ret);
        follow(ret, 1'b1, sp);
        exec(32'h20D58000, 0, sp, -1, -1, "sub_run_stop", ret);
        follow(ret, 1'b0, sp);
        exec(32'h19890000, 0, sp, -1, 4, "add_rst_t4", ret);
        follow(ret, 1'b0, sp);
        exec(32'h81234000, 3, sp, -1, 2, "div_rst_t1", ret);
        follow(ret, 1'b0, sp);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) op = 5'($urandom);
            else op = legal_ops[$urandom_range(0, 12)];
            ir = {op, 27'($urandom)};
            exec(ir, $urandom_range(0, 3), sp,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : -1,
                 ($urandom_range(0, 14) == 0) ? $urandom_range(0, 8) : -1,
                 "rand", ret);
            follow(ret, $urandom_range(0, 2) == 0, sp);
        end
        check(exp_q.size() == 0 ? W_T0 : 64'h0, "final_t0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
